// File: rtl/mems_pkg.sv
// mems_pkg: shared types for the MEMS mirror scan sequencer.
//   state_e : sequencer states (S_DWELL only used when MEMS_SCAN_DWELL_EN is set)
//   phase_e : init-word phase vs. scan-point phase
//   cnt_w() : counter width for a limit, never narrower than 1 bit
package mems_pkg;

   localparam int DEF_DATA_W = 24;
   localparam int DEF_ADDR_W = 16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_DWELL = 3'd4
   } state_e;

   typedef enum logic {
      PH_INIT = 1'b0,
      PH_SCAN = 1'b1
   } phase_e;

   function automatic int cnt_w(input int lim);
      return (lim < 2) ? 1 : $clog2(lim);
   endfunction

endpackage

// File: rtl/mems_scan_cnt.sv
// mems_scan_cnt: cascaded point -> line -> frame counter with wrap.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : synchronous clear of all counters (wins over adv_i)
//   adv_i         : advance by one scan point
//   eol_o         : current point is the last of its line
//   eof_o         : ... and the line is the last of its frame
//   eos_o         : ... and the frame is the last of the scan cycle
module mems_scan_cnt
   import mems_pkg::*;
#(
   parameter int POINTS_PER_LINE = 384,
   parameter int LINES_PER_FRAME = 20,
   parameter int FRAMES          = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic adv_i,
   output logic eol_o,
   output logic eof_o,
   output logic eos_o
);

   localparam int PW = cnt_w(POINTS_PER_LINE);
   localparam int LW = cnt_w(LINES_PER_FRAME);
   localparam int FW = cnt_w(FRAMES);

   logic [PW-1:0] pt_q, pt_d;
   logic [LW-1:0] line_q, line_d;
   logic [FW-1:0] frm_q, frm_d;

   assign eol_o = (pt_q == PW'(POINTS_PER_LINE - 1));
   assign eof_o = eol_o && (line_q == LW'(LINES_PER_FRAME - 1));
   assign eos_o = eof_o && (frm_q == FW'(FRAMES - 1));

   always_comb begin
      pt_d   = pt_q;
      line_d = line_q;
      frm_d  = frm_q;
      if (clr_i) begin
         pt_d   = '0;
         line_d = '0;
         frm_d  = '0;
      end else if (adv_i) begin
         if (!eol_o) begin
            pt_d = pt_q + PW'(1);
         end else begin
            pt_d = '0;
            if (!eof_o) begin
               line_d = line_q + LW'(1);
            end else begin
               line_d = '0;
               frm_d  = eos_o ? '0 : frm_q + FW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pt_q   <= '0;
         line_q <= '0;
         frm_q  <= '0;
      end else begin
         pt_q   <= pt_d;
         line_q <= line_d;
         frm_q  <= frm_d;
      end
   end

endmodule

// File: rtl/mems_scan_ctrl.sv
// mems_scan_ctrl: MEMS mirror scan sequencer for the DAC SPI path.
// Plays INIT_WORDS init words from ROM addresses 0.., then streams scan
// points from INIT_WORDS.. with wrap, one start/busy handshake per word.
// Ports:
//   clk, rst (async active-low)
//   mems_soft_reset     : (re)start the init sequence, clears flags
//   pause               : blocks new starts in the scan phase
//   mems_SPI_busy       : SPI master busy
//   new_line/frame_FIFO_done : clear the sticky flags
//   rom_addr / rom_data : external synchronous ROM (1-cycle latency)
//   mems_SPI_start      : one-cycle start pulse, data_mosi carries the word
//   new_line, new_frame, flag_overrun : sticky status flags
//   scanning            : scan phase active
// Build option: define MEMS_SCAN_DWELL_EN to add dwell_cycles[15:0] and a
// DWELL state inserting that many idle clocks between scan points.
module mems_scan_ctrl
   import mems_pkg::*;
#(
   parameter int DATA_W          = DEF_DATA_W,
   parameter int ADDR_W          = DEF_ADDR_W,
   parameter int INIT_WORDS      = 2,
   parameter int POINTS_PER_LINE = 384,
   parameter int LINES_PER_FRAME = 20,
   parameter int FRAMES          = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mems_soft_reset,
   input  logic              pause,
   input  logic              mems_SPI_busy,
   input  logic              new_line_FIFO_done,
   input  logic              new_frame_FIFO_done,
`ifdef MEMS_SCAN_DWELL_EN
   input  logic [15:0]       dwell_cycles,
`endif
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              mems_SPI_start,
   output logic [DATA_W-1:0] data_mosi,
   output logic              new_line,
   output logic              new_frame,
   output logic              flag_overrun,
   output logic              scanning
);

   localparam longint TOTAL = longint'(INIT_WORDS) +
      longint'(POINTS_PER_LINE) * longint'(LINES_PER_FRAME) * longint'(FRAMES);

   if (TOTAL > (longint'(1) << ADDR_W)) begin : g_addr_chk
      $error("mems_scan_ctrl: init words plus scan points exceed ROM address space");
   end
   if (INIT_WORDS < 1) begin : g_init_chk
      $error("mems_scan_ctrl: INIT_WORDS must be at least 1");
   end

   localparam logic [ADDR_W-1:0] SCAN_BASE = ADDR_W'(INIT_WORDS);
   localparam logic [ADDR_W-1:0] LAST_INIT = ADDR_W'(INIT_WORDS - 1);

   state_e            state_q, state_d;
   phase_e            phase_q, phase_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              start_q;
   logic              nl_q, nl_d, nf_q, nf_d, ovr_q, ovr_d;
   logic              cnt_clr, cnt_adv;
   logic              cnt_eol, cnt_eof, cnt_eos;
   logic              ev_line, ev_frame;
`ifdef MEMS_SCAN_DWELL_EN
   logic [15:0]       dwell_q, dwell_d;
`endif

   mems_scan_cnt #(
      .POINTS_PER_LINE (POINTS_PER_LINE),
      .LINES_PER_FRAME (LINES_PER_FRAME),
      .FRAMES          (FRAMES)
   ) u_cnt (
      .clk_i  (clk),
      .rst_ni (rst),
      .clr_i  (cnt_clr),
      .adv_i  (cnt_adv),
      .eol_o  (cnt_eol),
      .eof_o  (cnt_eof),
      .eos_o  (cnt_eos)
   );

   assign rom_addr       = addr_q;
   assign mems_SPI_start = (state_q == S_START);
   assign data_mosi      = (state_q == S_IDLE) ? '0 : rom_data;
   assign new_line       = nl_q;
   assign new_frame      = nf_q;
   assign flag_overrun   = ovr_q;
   assign scanning       = (phase_q == PH_SCAN);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      addr_d  = addr_q;
      cnt_clr = 1'b0;
      cnt_adv = 1'b0;
`ifdef MEMS_SCAN_DWELL_EN
      dwell_d = dwell_q;
`endif
      if (mems_soft_reset) begin
         state_d = S_FETCH;
         phase_d = PH_INIT;
         addr_d  = '0;
         cnt_clr = 1'b1;
`ifdef MEMS_SCAN_DWELL_EN
         dwell_d = '0;
`endif
      end else begin
         case (state_q)
            S_IDLE:  state_d = S_IDLE;
            // Busy check also covers a soft reset that landed mid-transfer.
            S_FETCH: if (!mems_SPI_busy && !(phase_q == PH_SCAN && pause)) state_d = S_START;
            S_START: state_d = S_WAIT;
            // start_q masks busy in the first WAIT cycle, before the master reacts.
            S_WAIT: begin
               if (!mems_SPI_busy && !start_q) begin
                  state_d = S_FETCH;
                  if (phase_q == PH_INIT) begin
                     if (addr_q == LAST_INIT) begin
                        phase_d = PH_SCAN;
                        addr_d  = SCAN_BASE;
                        cnt_clr = 1'b1;
                     end else begin
                        addr_d = addr_q + ADDR_W'(1);
                     end
                  end else begin
                     cnt_adv = 1'b1;
                     addr_d  = cnt_eos ? SCAN_BASE : addr_q + ADDR_W'(1);
`ifdef MEMS_SCAN_DWELL_EN
                     if (dwell_cycles != 16'd0) begin
                        state_d = S_DWELL;
                        dwell_d = dwell_cycles;
                     end
`endif
                  end
               end
            end
`ifdef MEMS_SCAN_DWELL_EN
            S_DWELL: begin
               if (dwell_q <= 16'd1) state_d = S_FETCH;
               else                  dwell_d = dwell_q - 16'd1;
            end
`endif
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Flag events fire on the START of the last point of a line/frame, so the
   // flags appear the cycle after that start. Set beats a coincident clear.
   always_comb begin
      ev_line  = (state_q == S_START) && (phase_q == PH_SCAN) && cnt_eol;
      ev_frame = (state_q == S_START) && (phase_q == PH_SCAN) && cnt_eof;
      nl_d  = ev_line  | (nl_q & ~new_line_FIFO_done);
      nf_d  = ev_frame | (nf_q & ~new_frame_FIFO_done);
      ovr_d = ovr_q | (ev_line  & nl_q & ~new_line_FIFO_done)
                    | (ev_frame & nf_q & ~new_frame_FIFO_done);
      if (mems_soft_reset) begin
         nl_d  = 1'b0;
         nf_d  = 1'b0;
         ovr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         phase_q <= PH_INIT;
         addr_q  <= '0;
         start_q <= 1'b0;
         nl_q    <= 1'b0;
         nf_q    <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef MEMS_SCAN_DWELL_EN
         dwell_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         addr_q  <= addr_d;
         start_q <= (state_q == S_START);
         nl_q    <= nl_d;
         nf_q    <= nf_d;
         ovr_q   <= ovr_d;
`ifdef MEMS_SCAN_DWELL_EN
         dwell_q <= dwell_d;
`endif
      end
   end

endmodule

// File: tb/tb_mems_scan_ctrl.sv
// tb_mems_scan_ctrl: self-checking bench for mems_scan_ctrl with a small
// scan geometry (4 points x 3 lines x 2 frames, 2 init words), a registered
// ROM model and an SPI model holding busy for busy_len cycles per start.
// The reference model tracks expected word order, flag set/clear and
// overrun purely from observed start pulses and the driven inputs.
// With MEMS_SCAN_DWELL_EN defined the dwell gap is also checked.
module tb_mems_scan_ctrl;

   localparam int IW   = 2;
   localparam int PPL  = 4;
   localparam int LPF  = 3;
   localparam int FR   = 2;
   localparam int NPTS = PPL * LPF * FR;
   localparam int LAST = IW + NPTS - 1;

   logic        clk;
   logic        rst;
   logic        mems_soft_reset, pause, busy;
   logic        new_line_FIFO_done, new_frame_FIFO_done;
   logic [15:0] rom_addr;
   logic [23:0] rom_data;
   logic        mems_SPI_start;
   logic [23:0] data_mosi;
   logic        new_line, new_frame, flag_overrun, scanning;
`ifdef MEMS_SCAN_DWELL_EN
   logic [15:0] dwell_cycles;
`endif

   mems_scan_ctrl #(
      .DATA_W(24), .ADDR_W(16), .INIT_WORDS(IW),
      .POINTS_PER_LINE(PPL), .LINES_PER_FRAME(LPF), .FRAMES(FR)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .mems_soft_reset     (mems_soft_reset),
      .pause               (pause),
      .mems_SPI_busy       (busy),
      .new_line_FIFO_done  (new_line_FIFO_done),
      .new_frame_FIFO_done (new_frame_FIFO_done),
`ifdef MEMS_SCAN_DWELL_EN
      .dwell_cycles        (dwell_cycles),
`endif
      .rom_addr            (rom_addr),
      .rom_data            (rom_data),
      .mems_SPI_start      (mems_SPI_start),
      .data_mosi           (data_mosi),
      .new_line            (new_line),
      .new_frame           (new_frame),
      .flag_overrun        (flag_overrun),
      .scanning            (scanning)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM and SPI responders
   logic [23:0] rom_mem [0:63];
   int          busy_len;
   int          bcnt;
   always @(posedge clk) rom_data <= rom_mem[rom_addr[5:0]];
   always @(posedge clk or negedge rst) begin
      if (!rst)                bcnt <= 0;
      else if (mems_SPI_start) bcnt <= busy_len;
      else if (bcnt != 0)      bcnt <= bcnt - 1;
   end
   assign busy = (bcnt != 0);

   int vec, errs;
   int cyc, last_cyc, n_starts, last_gap, exp_addr, st_addr;
   bit saw_start, prev_pause;
   bit e_line, e_frame, e_ovr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference model step, run at the falling edge of every cycle.
   task automatic model_step();
      bit ev_l, ev_f;
      int a, idx;
      ev_l = 0; ev_f = 0; saw_start = 0;
      cyc++;
      chk("new_line", new_line, e_line);
      chk("new_frame", new_frame, e_frame);
      chk("overrun", flag_overrun, e_ovr);
      if (mems_SPI_start) begin
         a = int'(rom_addr);
         saw_start = 1; st_addr = a;
         chk("start_addr", rom_addr, exp_addr);
         chk("mosi", data_mosi, rom_mem[rom_addr[5:0]]);
         chk("busy_at_start", busy, 0);
         chk("scanning", scanning, a >= IW);
         if (n_starts > 0) begin
            last_gap = cyc - last_cyc;
            chk("gap_ge3", last_gap >= 3, 1);
         end
         if (a >= IW) chk("pause_gate", prev_pause, 0);
         last_cyc = cyc; n_starts++;
         if (a >= IW) begin
            idx  = a - IW;
            ev_l = (idx % PPL) == PPL - 1;
            ev_f = (idx % (PPL * LPF)) == PPL * LPF - 1;
            exp_addr = (a == LAST) ? IW : a + 1;
         end else begin
            exp_addr = a + 1;
         end
      end
      if (!rst || mems_soft_reset) begin
         e_line = 0; e_frame = 0; e_ovr = 0; exp_addr = 0;
         if (!rst) n_starts = 0;
      end else begin
         e_ovr   = e_ovr | (ev_l & e_line & !new_line_FIFO_done)
                         | (ev_f & e_frame & !new_frame_FIFO_done);
         e_line  = ev_l | (e_line & !new_line_FIFO_done);
         e_frame = ev_f | (e_frame & !new_frame_FIFO_done);
      end
      prev_pause = pause;
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(input string tag, input int a, input int budget);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (saw_start && st_addr == a) begin
            ok = 1;
            break;
         end
      end
      chk(tag, ok, 1);
   endtask

   task automatic soft_pulse();
      mems_soft_reset = 1'b1;
      tick();
      mems_soft_reset = 1'b0;
   endtask

   initial begin
      int cnt, g0, g1;
      vec = 0; errs = 0; cyc = 0; last_cyc = 0; n_starts = 0; last_gap = 0;
      exp_addr = 0; st_addr = 0; saw_start = 0; prev_pause = 0;
      e_line = 0; e_frame = 0; e_ovr = 0;
      busy_len = 5;
      for (int i = 0; i < 64; i++) rom_mem[i] = 24'($urandom);
      rst = 1'b0; mems_soft_reset = 0; pause = 0;
      new_line_FIFO_done = 0; new_frame_FIFO_done = 0;
`ifdef MEMS_SCAN_DWELL_EN
      dwell_cycles = 16'd0;
`endif
      @(posedge clk); #1;
      chk("rst_addr", rom_addr, 0);
      chk("rst_start", mems_SPI_start, 0);
      chk("rst_flags", {new_line, new_frame, flag_overrun}, 0);
      chk("rst_scanning", scanning, 0);
      chk("rst_mosi", data_mosi, 0);
      tick();
      rst = 1'b1;

      // IDLE must not start anything on its own
      cnt = 0;
      for (int i = 0; i < 6; i++) begin tick(); if (saw_start) cnt++; end
      chk("idle_no_start", cnt, 0);
      chk("idle_addr", rom_addr, 0);

      soft_pulse();
      run_to("reach_a4", 4, 100);
      new_line_FIFO_done = 1'b1;       // clear held across the set at addr 5
      run_to("reach_a5", 5, 40);
      new_line_FIFO_done = 1'b0;
      chk("a5_new_line", new_line, 1);
      chk("a5_new_frame", new_frame, 0);
      chk("a5_no_overrun", flag_overrun, 0);
      run_to("reach_a9", 9, 60);
      chk("a9_overrun", flag_overrun, 1);

      run_to("reach_a10", 10, 40);
      pause = 1'b1;
      cnt = 0;
      for (int i = 0; i < 15; i++) begin tick(); if (saw_start) cnt++; end
      chk("paused_no_start", cnt, 0);
      pause = 1'b0;
      run_to("resume_a11", 11, 2);

      run_to("reach_a13", 13, 40);
      chk("a13_new_line", new_line, 1);
      chk("a13_new_frame", new_frame, 1);
      run_to("reach_a25", LAST, 200);
      run_to("wrap_to_a2", IW, 20);

      // randomized traffic: flag clears, pause, busy length, rare soft reset
      for (int i = 0; i < 3000; i++) begin
         new_line_FIFO_done  = ($urandom_range(0, 7) == 0);
         new_frame_FIFO_done = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) pause = ~pause;
         mems_soft_reset = ($urandom_range(0, 999) == 0);
         busy_len = $urandom_range(1, 7);
         tick();
      end
      new_line_FIFO_done = 0; new_frame_FIFO_done = 0;
      pause = 0; mems_soft_reset = 0; busy_len = 5;

      // soft reset while a scan word is in flight
      run_to("reach_a20", 20, 600);
      tick(); tick();
      chk("sr_busy_before", busy, 1);
      soft_pulse();
      chk("sr_flags", {new_line, new_frame, flag_overrun}, 0);
      chk("sr_scanning", scanning, 0);
      run_to("sr_restart_a0", 0, 20);
      run_to("sr_a1", 1, 40);

`ifdef MEMS_SCAN_DWELL_EN
      run_to("dw_a15", 15, 300);
      run_to("dw_a16", 16, 40);
      g0 = last_gap;
      dwell_cycles = 16'd4;
      run_to("dw_a17", 17, 40);
      g1 = last_gap;
      chk("dwell_gap_delta", g1 - g0, 4);
      dwell_cycles = 16'd0;
`else
      g0 = 0; g1 = 0;
      chk("no_dwell_gaps", g1 - g0, 0);
`endif

      // asynchronous reset in the middle of WAIT
      run_to("ar_a3", 3, 200);
      tick();
      rst = 1'b0;
      #1;
      chk("ar_addr", rom_addr, 0);
      chk("ar_start", mems_SPI_start, 0);
      chk("ar_flags", {new_line, new_frame, flag_overrun}, 0);
      chk("ar_scanning", scanning, 0);
      chk("ar_mosi", data_mosi, 0);
      e_line = 0; e_frame = 0; e_ovr = 0; exp_addr = 0; n_starts = 0;
      tick(); tick();
      rst = 1'b1;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin tick(); if (saw_start) cnt++; end
      chk("ar_idle", cnt, 0);
      soft_pulse();
      run_to("ar_recover_a2", IW, 60);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule

// File: doc/mems_scan_ctrl.md
Name: mems_scan_ctrl

Overview:
Parametrised MEMS mirror scan sequencer for the DAC SPI path. It runs a DAC init word sequence and then streams scan-point words from a synchronous ROM to the SPI master, one start/busy handshake per word. Line and frame boundaries are computed from counters, not hard-coded address lists. It raises sticky new_line/new_frame flags, which the FIFO/readout side clears with done pulses.

Parameters:
DATA_W, 24, DAC SPI word width
ADDR_W, 16, ROM address width
INIT_WORDS, 2, init words at ROM addresses 0..INIT_WORDS-1 (soft reset, VREF setup)
POINTS_PER_LINE, 384, scan points per line
LINES_PER_FRAME, 20, lines per frame
FRAMES, 2, frames per scan cycle before wrap

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
mems_soft_reset  input  1  pulse: (re)start init sequence
pause  input  1  hold scan (no new starts while high)
mems_SPI_busy  input  1  SPI master busy
new_line_FIFO_done  input  1  clears new_line
new_frame_FIFO_done  input  1  clears new_frame
rom_addr  output  ADDR_W  ROM address (registered)
rom_data  input  DATA_W  ROM data, valid 1 cycle after rom_addr
mems_SPI_start  output  1  one-cycle start pulse
data_mosi  output  DATA_W  word to SPI master (= rom_data)
new_line  output  1  sticky line-end flag
new_frame  output  1  sticky frame-end flag
flag_overrun  output  1  sticky: flag set while already set
scanning  output  1  high in scan phase

Behaviour:
- Reset (rst=0, async): state IDLE; rom_addr=0; all outputs and counters 0.
- States: IDLE, FETCH, START, WAIT. DWELL exists only under the optional feature.
- IDLE:
  - rom_addr=0; stay until mems_soft_reset=1, then go to FETCH with phase=INIT.
- FETCH (1 cycle):
  - rom_addr is stable here; rom_data is valid at the end of this cycle.
  - Go to START, unless phase=SCAN and pause=1, in which case hold in FETCH.
- START (1 cycle):
  - mems_SPI_start=1; next state WAIT.
- WAIT:
  - Ignore busy in the first cycle after START.
  - Exit when mems_SPI_busy=0 and the start pulse register is 0.
  - Then advance the address and go to FETCH.
  - Minimum gap between starts is 3 cycles.
- Address advance, init phase:
  - addr+1.
  - After word INIT_WORDS-1: phase=SCAN, addr=INIT_WORDS, counters cleared.
- Address advance, scan phase:
  - pt_cnt counts 0..POINTS_PER_LINE-1, then line_cnt counts 0..LINES_PER_FRAME-1, then frm_cnt counts 0..FRAMES-1.
  - After the last point of the last frame: addr wraps to INIT_WORDS and all counters go to 0 (wrap-around).
- new_line:
  - Set the cycle after START of the last point of a line (pt_cnt=POINTS_PER_LINE-1).
- new_frame:
  - Set on the same cycle as new_line when the line is also the last of its frame.
  - At a frame end both flags set together.
- Flag clear:
  - Each flag is cleared by its *_FIFO_done (level, any cycle).
  - If set and clear coincide, set wins.
- flag_overrun:
  - Set if a flag-set event hits a flag that is already 1 (no clear in the same cycle).
  - Cleared only by reset or mems_soft_reset.
- pause:
  - Ignored in the init phase.
  - In-flight transfers always complete; pause only blocks FETCH->START.
- mems_soft_reset in any non-IDLE state:
  - Abort to FETCH with phase=INIT and addr=0.
  - Clear counters, flags and flag_overrun.
  - If SPI is busy, wait for busy=0 before the next START.
- Counter widths: $clog2 of each limit. Elaboration error if INIT_WORDS + total points > 2**ADDR_W.

Optional Feature:
- Macro: MEMS_SCAN_DWELL_EN.
- With the macro:
  - Extra input dwell_cycles[15:0].
  - In the scan phase, WAIT exit goes to DWELL and counts dwell_cycles clocks before FETCH.
  - dwell_cycles=0 means no extra cycles.
  - mems_soft_reset aborts DWELL immediately.
- Without the macro: no port, no DWELL state, WAIT goes directly to FETCH.

Decomposition:
- Package mems_pkg:
  - state enum (IDLE/FETCH/START/WAIT/DWELL);
  - default DATA_W/ADDR_W;
  - phase encoding.
- Sub-module mems_scan_cnt: cascaded point/line/frame counter with wrap, exposing end_of_line/end_of_frame/end_of_scan strobes.
- The ROM stays external.

Test Plan:
Setup: POINTS_PER_LINE=4, LINES_PER_FRAME=3, FRAMES=2, INIT_WORDS=2; the SPI model asserts busy for 5 cycles after each start.
- Soft reset pulse -> starts with rom_addr 0, 1, then 2..25, then wraps to 2; start pulses are 1 cycle and ≥3 cycles apart.
- Scan addr 5 (4th point) started -> new_line=1 next cycle, new_frame=0. Addr 13 started -> both flags =1.
- new_line_FIFO_done pulsed in the same cycle as a new_line set -> new_line stays 1, flag_overrun=1 only if new_line was already 1.
- pause=1 during busy at addr 10 -> transfer completes, no start while paused; release -> next start at addr 11 within 2 cycles.
- mems_soft_reset mid-scan while busy -> flags cleared, no start until busy falls, next word from addr 0.
- Async rst low mid-WAIT -> all outputs 0 immediately; with MEMS_SCAN_DWELL_EN and dwell_cycles=4, scan start gap grows by exactly 4 cycles.
